// File: rtl/channel_capture_pkg.sv
// Shared definitions for the logic-analyser channel capture stage: state and
// trigger-mode encodings plus the default sample depth shared with the display stage.
package channel_capture_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 256;

    typedef enum logic [1:0] {
        CC_IDLE    = 2'd0,
        CC_ARMED   = 2'd1,
        CC_CAPTURE = 2'd2,
        CC_DONE    = 2'd3
    } cc_state_e;

    localparam logic [1:0] TRIG_FREE = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;
    localparam logic [1:0] TRIG_ANY  = 2'd3;

    // Edge modes need a valid previous sample; free-run always fires.
    function automatic logic trig_hit(input logic [1:0] mode, input logic prev_valid,
                                      input logic prev, input logic cur);
        logic hit;
        hit = 1'b0;
        case (mode)
            TRIG_FREE: hit = 1'b1;
            TRIG_RISE: hit = prev_valid & ~prev & cur;
            TRIG_FALL: hit = prev_valid & prev & ~cur;
            default:   hit = prev_valid & (prev ^ cur);
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/channel_capture_sample_ticker.sv
// Programmable sample-rate divider: tick every prescale+1 enabled cycles.
// The divide ratio is latched while cleared and at each wrap.
module channel_capture_sample_ticker #(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] lim_q, lim_d;

    assign tick = enable && !clear && (cnt_q == lim_q);

    always_comb begin
        cnt_d = cnt_q;
        lim_d = lim_q;
        if (clear) begin
            cnt_d = '0;
            lim_d = prescale;
        end else if (enable) begin
            if (tick) begin
                cnt_d = '0;
                lim_d = prescale;
            end else begin
                cnt_d = cnt_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

endmodule

// File: rtl/channel_capture.sv
// One logic-analyser channel: synchronise, sample at a programmable rate, wait for a
// trigger, fill a DATA_SIZE buffer and publish it only at frame start.
module channel_capture
    import channel_capture_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = DEFAULT_DATA_SIZE,
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sig_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [1:0]                trig_mode,
    input  logic                      continuous,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      frame_start,
    output logic [DATA_SIZE-1:0]      data,
    output logic                      data_valid,
    output logic                      capture_done,
    output logic                      busy
);

    localparam int unsigned CntW = $clog2(DATA_SIZE) + 1;

    cc_state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [CntW-1:0]      count_inc;
    logic                 prev_q, prev_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 data_valid_q, data_valid_d;
    logic                 capture_done_q, capture_done_d;
    logic                 s;
    logic                 running;
    logic                 tick;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    assign s       = sync_q[SYNC_STAGES-1];
    assign running = (state_q == CC_ARMED) || (state_q == CC_CAPTURE);

    // Held clear outside ARMED/CAPTURE, so every entry to ARMED starts from zero.
    channel_capture_sample_ticker #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_ticker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!running),
        .enable  (running),
        .prescale(prescale),
        .tick    (tick)
    );

    assign count_inc = count_q + CntW'(1);

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        count_d        = count_q;
        prev_d         = prev_q;
        prev_valid_d   = prev_valid_q;
        data_d         = data_q;
        data_valid_d   = data_valid_q;
        capture_done_d = 1'b0;
        if (abort) begin
            state_d      = CC_IDLE;
            prev_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                CC_IDLE: begin
                    prev_valid_d = 1'b0;
                    if (arm) state_d = CC_ARMED;
                end
                CC_ARMED: begin
                    if (tick) begin
                        prev_d       = s;
                        prev_valid_d = 1'b1;
                        if (trig_hit(trig_mode, prev_valid_q, prev_q, s)) begin
                            state_d = CC_CAPTURE;
                            shift_d = {s, shift_q[DATA_SIZE-1:1]};
                            count_d = CntW'(1);
                        end
                    end
                end
                CC_CAPTURE: begin
                    // Right shift with MSB entry leaves sample k in bit k after the last tick.
                    if (tick) begin
                        shift_d = {s, shift_q[DATA_SIZE-1:1]};
                        count_d = count_inc;
                        if (count_inc == CntW'(DATA_SIZE)) state_d = CC_DONE;
                    end
                end
                CC_DONE: begin
                    prev_valid_d = 1'b0;
                    if (frame_start) begin
                        data_d         = shift_q;
                        data_valid_d   = 1'b1;
                        capture_done_d = 1'b1;
                        state_d        = continuous ? CC_ARMED : CC_IDLE;
                    end
                end
                default: state_d = CC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CC_IDLE;
            sync_q         <= '0;
            shift_q        <= '0;
            count_q        <= '0;
            prev_q         <= 1'b0;
            prev_valid_q   <= 1'b0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            capture_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            shift_q        <= shift_d;
            count_q        <= count_d;
            prev_q         <= prev_d;
            prev_valid_q   <= prev_valid_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            capture_done_q <= capture_done_d;
        end
    end

    assign data         = data_q;
    assign data_valid   = data_valid_q;
    assign capture_done = capture_done_q;
    assign busy         = (state_q != CC_IDLE);

endmodule

// File: tb/tb_channel_capture.sv
// Randomised bench for channel_capture: expected captures are derived from the recorded
// probe history, the tick schedule and the trigger rule.
module tb_channel_capture;
    import channel_capture_pkg::*;

    localparam int DS = 256;
    localparam int PW = 16;
    localparam int MAX_CYC = 65000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sig_in;
    logic [PW-1:0] prescale;
    logic [1:0]    trig_mode;
    logic          continuous;
    logic          arm;
    logic          abort;
    logic          frame_start;
    logic [DS-1:0] data;
    logic          data_valid;
    logic          capture_done;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    bit            sig_hist [0:65535];
    logic [DS-1:0] ref_data;
    logic          ref_valid;

    always #5 clk = ~clk;

    channel_capture u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .prescale    (prescale),
        .trig_mode   (trig_mode),
        .continuous  (continuous),
        .arm         (arm),
        .abort       (abort),
        .frame_start (frame_start),
        .data        (data),
        .data_valid  (data_valid),
        .capture_done(capture_done),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [DS-1:0] got,
                            input logic [DS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Advance to the next cycle; pulses default low, probe follows the recorded history.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAX_CYC) begin
            check_eq("cycle_budget", 0, 1);
            $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
            $fatal(1, "cycle budget exhausted");
        end
        arm         = 1'b0;
        abort       = 1'b0;
        frame_start = 1'b0;
        sig_in      = sig_hist[cyc];
    endtask

    task automatic fill_const(input int from, input int n, input bit v);
        for (int i = 0; i < n; i++) if (from + i < 65536) sig_hist[from + i] = v;
    endtask

    task automatic fill_random(input int from, input int n);
        bit v;
        int run;
        v   = bit'($urandom_range(0, 1));
        run = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
            if (from + i < 65536) sig_hist[from + i] = v;
            run--;
            if (run == 0) begin
                v   = ~v;
                run = $urandom_range(1, 12);
            end
        end
    endtask

    task automatic idle(input int n, input bit v);
        fill_const(cyc + 1, n, v);
        repeat (n) step();
    endtask

    // Arm in cycle a: ticks fall on cycles a+1+p+j*(p+1); the synchronised value seen
    // at cycle t is the probe value from cycle t-2.
    task automatic predict(input int a, input int p, input logic [1:0] mode,
                           output int last, output logic [DS-1:0] exp, output bit ok);
        int  t0, trig;
        bit  cur, prv, hit;
        t0   = a + 1 + p;
        ok   = 1'b0;
        trig = 0;
        exp  = '0;
        for (int j = 0; j < 128 && !ok; j++) begin
            cur = sig_hist[t0 + j * (p + 1) - 2];
            prv = (j > 0) ? sig_hist[t0 + (j - 1) * (p + 1) - 2] : 1'b0;
            if (mode == TRIG_FREE)      hit = 1'b1;
            else if (mode == TRIG_RISE) hit = (j > 0) && !prv && cur;
            else if (mode == TRIG_FALL) hit = (j > 0) && prv && !cur;
            else                        hit = (j > 0) && (prv != cur);
            if (hit) begin
                ok   = 1'b1;
                trig = j;
            end
        end
        for (int k = 0; k < DS; k++) exp[k] = sig_hist[t0 + (trig + k) * (p + 1) - 2];
        last = t0 + (trig + DS - 1) * (p + 1);
    endtask

    // One capture from IDLE (or auto re-armed after the previous publish), checked every cycle.
    task automatic capture(input int p, input logic [1:0] mode, input bit cont, input bit rearm,
                           input bit prefilled, input bit ign, input int gap);
        int            a, last, f;
        logic [DS-1:0] exp;
        bit            ok;
        if (!prefilled) fill_random(cyc + 1, (p + 1) * (DS + 140) + 80);
        trig_mode  = mode;
        continuous = cont;
        if (rearm) begin
            a = cyc - 1;
        end else begin
            prescale = PW'(p);
            a        = cyc + 1;
        end
        predict(a, p, mode, last, exp, ok);
        if (!ok) begin
            $display("note: stimulus window had no trigger, scenario skipped");
            return;
        end
        f = last + 1 + gap;
        while (cyc < f + 1) begin
            step();
            if (!rearm && cyc == a) arm = 1'b1;
            if (cyc == f || (ign && cyc == last)) frame_start = 1'b1;
            @(negedge clk);
            check_eq("busy", busy, (cyc <= f) ? (rearm || cyc > a) : cont);
            check_eq("capture_done", capture_done, cyc == f + 1);
            check_eq("data", data, (cyc <= f) ? ref_data : exp);
            check_eq("data_valid", data_valid, (cyc <= f) ? ref_valid : 1'b1);
        end
        ref_data  = exp;
        ref_valid = 1'b1;
    endtask

    // Free-run capture aborted 'off' cycles after arm; a later frame_start must not publish.
    task automatic run_abort(input int off);
        int a;
        fill_const(cyc + 1, off + 12, 1'b1);
        prescale   = '0;
        trig_mode  = TRIG_FREE;
        continuous = 1'b0;
        a          = cyc + 1;
        while (cyc < a + off + 8) begin
            step();
            if (cyc == a) arm = 1'b1;
            if (cyc == a + off) abort = 1'b1;
            if (cyc == a + off + 3) frame_start = 1'b1;
            @(negedge clk);
            check_eq("abort_busy", busy, (cyc > a) && (cyc <= a + off));
            check_eq("abort_done", capture_done, 0);
            check_eq("abort_data", data, ref_data);
            check_eq("abort_valid", data_valid, ref_valid);
        end
        step();
        arm   = 1'b1;
        abort = 1'b1;
        repeat (3) begin
            step();
            @(negedge clk);
            check_eq("arm_abort_idle", busy, 0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        sig_in      = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
        frame_start = 1'b0;
        continuous  = 1'b0;
        prescale    = '0;
        trig_mode   = TRIG_FREE;
        ref_data    = '0;
        ref_valid   = 1'b0;
        #12;
        check_eq("rst_data", data, 0);
        check_eq("rst_valid", data_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", capture_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1);

        // Free-run, constant high, frame_start about 300 cycles after arm.
        fill_const(cyc + 1, 400, 1'b1);
        capture(0, TRIG_FREE, 1'b0, 1'b0, 1'b1, 1'b0, 43);
        check_eq("free_all_ones", data, {DS{1'b1}});

        // Rising: 20 low, 100 high; frame_start at completion cycle must be ignored.
        idle(4, 1'b0);
        fill_const(cyc + 1, 20, 1'b0);
        fill_const(cyc + 21, 100, 1'b1);
        fill_const(cyc + 121, 400, 1'b0);
        capture(0, TRIG_RISE, 1'b0, 1'b0, 1'b1, 1'b1, 10);
        check_eq("rise_100", data, {{(DS - 100){1'b0}}, {100{1'b1}}});

        // Rising, prescale 3: 40-cycle pulse aligned to the sample points gives 10 ones.
        idle(8, 1'b0);
        fill_const(cyc + 1, 22, 1'b0);
        fill_const(cyc + 23, 40, 1'b1);
        fill_const(cyc + 63, 1200, 1'b0);
        capture(3, TRIG_RISE, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        check_eq("pre3_ten", data, {{(DS - 10){1'b0}}, {10{1'b1}}});

        for (int i = 0; i < 5; i++) begin
            idle(2, 1'b0);
            capture($urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 30));
        end

        // Continuous: second capture starts from the first publish and lands on a later frame.
        idle(2, 1'b0);
        capture(1, TRIG_ANY, 1'b1, 1'b0, 1'b0, 1'b1, 7);
        capture(1, TRIG_FALL, 1'b0, 1'b1, 1'b0, 1'b0, 12);

        run_abort(51);
        run_abort(262);

        // Asynchronous reset between clock edges in the middle of a capture.
        fill_const(cyc + 1, 200, 1'b1);
        prescale  = '0;
        trig_mode = TRIG_FREE;
        step();
        arm = 1'b1;
        repeat (100) step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data", data, 0);
        check_eq("arst_valid", data_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", capture_done, 0);
        step();
        @(negedge clk);
        rst_n     = 1'b1;
        ref_data  = '0;
        ref_valid = 1'b0;
        idle(4, 1'b0);
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        capture(0, TRIG_RISE, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/channel_capture.md
Name: channel_capture

Overview:
- Upstream acquisition stage for one logic-analyser channel.
- Synchronises an asynchronous input and samples it at a programmable rate.
- Waits for a trigger condition, then fills a DATA_SIZE-sample buffer.
- Publishes the buffer as the per-channel `data` vector consumed by the pixel-status stage; updates only at frame start so no frame tears.

Parameters:
- DATA_SIZE, 256, samples per capture; equals `data` width of the display stage.
- PRESCALE_WIDTH, 16, width of sample-rate divider.
- SYNC_STAGES, 2, flip-flops in the input synchroniser (min 2).

Ports:
- clk  in  1  system/pixel clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sig_in  in  1  raw asynchronous probe input.
- prescale  in  PRESCALE_WIDTH  sample every prescale+1 clocks.
- trig_mode  in  2  00 free-run, 01 rising, 10 falling, 11 any edge.
- continuous  in  1  1 = re-arm automatically after publish.
- arm  in  1  one-cycle pulse, starts acquisition from IDLE.
- abort  in  1  one-cycle pulse, returns to IDLE from any state.
- frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blank.
- data  out  DATA_SIZE  published capture; data[0] = earliest sample (leftmost column).
- data_valid  out  1  high once any capture has been published.
- capture_done  out  1  one-cycle pulse in the cycle `data` updates.
- busy  out  1  high in ARMED, CAPTURE, DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; synchroniser, prescale counter, sample counter, shift register, prev_sample, data, data_valid, capture_done all 0.
- Synchroniser: sig_in passes through SYNC_STAGES flops; `s` = last stage. Latency sig_in→s = SYNC_STAGES cycles.
- Sample tick: prescale counter runs in ARMED and CAPTURE. tick=1 when counter==prescale, then counter→0. Counter is cleared on entry to ARMED. prescale=0 → tick every cycle. A change to prescale takes effect at the next wrap.
- States (2-bit): IDLE, ARMED, CAPTURE, DONE.
- IDLE: arm=1 → ARMED. frame_start is ignored.
- ARMED, on each tick:
  - prev_sample←s.
  - Trigger when mode 00; or mode 01 and prev=0,s=1; or mode 10 and prev=1,s=0; or mode 11 and prev≠s.
  - On the first tick after arming, prev_sample is not yet valid: the edge modes cannot fire; free-run fires.
  - Trigger → CAPTURE. The trigger-tick sample is stored as sample 0; count←1.
- CAPTURE, on each tick:
  - Shift register shifts right, s enters MSB; count++.
  - When count reaches DATA_SIZE → DONE.
  - Net effect: sample k ends in bit k.
  - Count width is clog2(DATA_SIZE)+1.
- DONE: holds the shift register and waits for frame_start. On frame_start: data←shift register (registered, visible next cycle), capture_done pulses in that same cycle, data_valid←1. Next state ARMED if continuous=1, else IDLE.
- Interactions:
  - abort has priority over arm, trigger and frame_start in the same cycle.
  - abort in DONE discards the pending capture; data is unchanged.
  - arm outside IDLE is ignored.
  - `data` never changes except on a DONE→publish transition or reset.
  - frame_start in the same cycle capture completes is not used; publish waits for the next frame_start.
  - Reset mid-capture: immediate return to reset values; data is cleared.

Decomposition:
- Shared header (alongside VGA timing header):
  - state encodings CC_IDLE=0, CC_ARMED=1, CC_CAPTURE=2, CC_DONE=3.
  - trigger mode constants TRIG_FREE=0, TRIG_RISE=1, TRIG_FALL=2, TRIG_ANY=3.
  - DATA_SIZE default shared with the display stage.
- One sub-module: sample_ticker (prescale counter with clear input and tick output).

Test Plan:
- Free-run, prescale=0, sig_in=1 constant, arm, frame_start after 300 cycles → data=all ones, capture_done one pulse, data_valid=1, state IDLE.
- Rising, prescale=0: sig_in low 20 cycles, then high exactly 100 cycles, then low; arm at cycle 0; frame_start later → data[99:0]=1, data[255:100]=0.
- Rising, prescale=3: sig_in rises and stays high 40 clocks, aligned to a tick → data[9:0]=1, data[255:10]=0; ticks spaced 4 clocks apart.
- Frame sync: capture completes mid-frame → data unchanged until next frame_start, updates the following cycle; continuous=1 → busy stays 1 and a second capture publishes on a later frame.
- Abort in CAPTURE at count 50 → state IDLE, busy=0, data keeps previous value. Abort with arm in the same cycle from IDLE → stays IDLE.
- rst_n low for one cycle during CAPTURE (asynchronous, between clock edges) → data=0, data_valid=0, busy=0 immediately; a fresh arm then works normally.
